// File: rtl/vx_dcache_prefetch_perf.sv
// Dcache prefetch perf counters: requests issued, prefetch fills, and prefetched
// lines evicted before any demand hit (one tracking bit per line, per bank).

module vx_dcache_prefetch_perf_bank #(
    parameter int NUM_SETS = 64,
    parameter int NUM_WAYS = 4,
    parameter int SET_BITS = 6,
    parameter int WAY_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                perf_clear,
    input  logic                fill_valid,
    input  logic                fill_is_pf,
    input  logic [SET_BITS-1:0] fill_set,
    input  logic [WAY_BITS-1:0] fill_way,
    input  logic                hit_valid,
    input  logic [SET_BITS-1:0] hit_set,
    input  logic [WAY_BITS-1:0] hit_way,
    input  logic                evict_valid,
    input  logic [SET_BITS-1:0] evict_set,
    input  logic [WAY_BITS-1:0] evict_way,
    output logic                unused_evict
);

    // One "prefetched, not yet demanded" bit per line.
    logic [NUM_SETS-1:0][NUM_WAYS-1:0] pf_bits;

    // With a single way the way field is a dummy bit; always address way 0.
    function automatic logic [WAY_BITS-1:0] way_idx(input logic [WAY_BITS-1:0] w);
        return (NUM_WAYS == 1) ? '0 : w;
    endfunction

    logic hit_same_line;

    always_comb begin
        hit_same_line = hit_valid && (hit_set == evict_set)
                        && (way_idx(hit_way) == way_idx(evict_way));
        unused_evict  = 1'b0;
        if (evict_valid)
            unused_evict = pf_bits[evict_set][way_idx(evict_way)] && !hit_same_line;
    end

    // Later assignments override earlier ones, so fill beats evict beats hit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf_bits <= '0;
        end else if (perf_clear) begin
            pf_bits <= '0;
        end else begin
            if (hit_valid)
                pf_bits[hit_set][way_idx(hit_way)] <= 1'b0;
            if (evict_valid)
                pf_bits[evict_set][way_idx(evict_way)] <= 1'b0;
            if (fill_valid)
                pf_bits[fill_set][way_idx(fill_way)] <= fill_is_pf;
        end
    end

endmodule

module vx_dcache_prefetch_perf #(
    parameter int NUM_BANKS = 4,
    parameter int NUM_SETS  = 64,
    parameter int NUM_WAYS  = 4,
    parameter int CTR_WIDTH = 44,
    localparam int SET_BITS = $clog2(NUM_SETS),
    localparam int WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          perf_clear,
    input  logic [NUM_BANKS-1:0]          pf_req_fire,
    input  logic [NUM_BANKS-1:0]          fill_valid,
    input  logic [NUM_BANKS-1:0]          fill_is_pf,
    input  logic [NUM_BANKS*SET_BITS-1:0] fill_set,
    input  logic [NUM_BANKS*WAY_BITS-1:0] fill_way,
    input  logic [NUM_BANKS-1:0]          hit_valid,
    input  logic [NUM_BANKS*SET_BITS-1:0] hit_set,
    input  logic [NUM_BANKS*WAY_BITS-1:0] hit_way,
    input  logic [NUM_BANKS-1:0]          evict_valid,
    input  logic [NUM_BANKS*SET_BITS-1:0] evict_set,
    input  logic [NUM_BANKS*WAY_BITS-1:0] evict_way,
    output logic [CTR_WIDTH-1:0]          prefetch_requests,
    output logic [CTR_WIDTH-1:0]          prefetched_blocks,
    output logic [CTR_WIDTH-1:0]          unused_prefetched_blocks
);

    localparam int CNT_W = $clog2(NUM_BANKS) + 1;

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_BANKS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            c = c + CNT_W'(v[i]);
        return c;
    endfunction

    logic [NUM_BANKS-1:0] unused_evict;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        vx_dcache_prefetch_perf_bank #(
            .NUM_SETS (NUM_SETS),
            .NUM_WAYS (NUM_WAYS),
            .SET_BITS (SET_BITS),
            .WAY_BITS (WAY_BITS)
        ) bank (
            .clk          (clk),
            .reset        (reset),
            .perf_clear   (perf_clear),
            .fill_valid   (fill_valid[b]),
            .fill_is_pf   (fill_is_pf[b]),
            .fill_set     (fill_set[b*SET_BITS +: SET_BITS]),
            .fill_way     (fill_way[b*WAY_BITS +: WAY_BITS]),
            .hit_valid    (hit_valid[b]),
            .hit_set      (hit_set[b*SET_BITS +: SET_BITS]),
            .hit_way      (hit_way[b*WAY_BITS +: WAY_BITS]),
            .evict_valid  (evict_valid[b]),
            .evict_set    (evict_set[b*SET_BITS +: SET_BITS]),
            .evict_way    (evict_way[b*WAY_BITS +: WAY_BITS]),
            .unused_evict (unused_evict[b])
        );
    end

    logic [CNT_W-1:0] req_inc, fill_inc, unused_inc;
    logic [CTR_WIDTH-1:0] pf_req_cnt, pf_fill_cnt, pf_unused_cnt;

    assign req_inc    = popcnt(pf_req_fire);
    assign fill_inc   = popcnt(fill_valid & fill_is_pf);
    assign unused_inc = popcnt(unused_evict);

    // Counters wrap naturally; clear drops every event of its cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf_req_cnt    <= '0;
            pf_fill_cnt   <= '0;
            pf_unused_cnt <= '0;
        end else if (perf_clear) begin
            pf_req_cnt    <= '0;
            pf_fill_cnt   <= '0;
            pf_unused_cnt <= '0;
        end else begin
            pf_req_cnt    <= pf_req_cnt    + {{(CTR_WIDTH-CNT_W){1'b0}}, req_inc};
            pf_fill_cnt   <= pf_fill_cnt   + {{(CTR_WIDTH-CNT_W){1'b0}}, fill_inc};
            pf_unused_cnt <= pf_unused_cnt + {{(CTR_WIDTH-CNT_W){1'b0}}, unused_inc};
        end
    end

    assign prefetch_requests        = pf_req_cnt;
    assign prefetched_blocks        = pf_fill_cnt;
    assign unused_prefetched_blocks = pf_unused_cnt;

endmodule

// File: tb/tb_vx_dcache_prefetch_perf.sv
// Directed bench for vx_dcache_prefetch_perf: counter increments, tracking-bit
// priority, bank independence, async reset, wrap and perf_clear.

module tb_vx_dcache_prefetch_perf;

    localparam int NB = 4;
    localparam int SB = 6;
    localparam int WB = 2;
    localparam int CW = 44;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             perf_clear;
    logic [NB-1:0]    pf_req_fire, fill_valid, fill_is_pf, hit_valid, evict_valid;
    logic [NB*SB-1:0] fill_set, hit_set, evict_set;
    logic [NB*WB-1:0] fill_way, hit_way, evict_way;
    logic [CW-1:0]    prefetch_requests, prefetched_blocks, unused_prefetched_blocks;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vx_dcache_prefetch_perf dut (
        .clk                      (clk),
        .reset                    (reset),
        .perf_clear               (perf_clear),
        .pf_req_fire              (pf_req_fire),
        .fill_valid               (fill_valid),
        .fill_is_pf               (fill_is_pf),
        .fill_set                 (fill_set),
        .fill_way                 (fill_way),
        .hit_valid                (hit_valid),
        .hit_set                  (hit_set),
        .hit_way                  (hit_way),
        .evict_valid              (evict_valid),
        .evict_set                (evict_set),
        .evict_way                (evict_way),
        .prefetch_requests        (prefetch_requests),
        .prefetched_blocks        (prefetched_blocks),
        .unused_prefetched_blocks (unused_prefetched_blocks)
    );

    task automatic clr_in();
        perf_clear  = 1'b0;
        pf_req_fire = '0;
        fill_valid  = '0; fill_is_pf = '0; fill_set  = '0; fill_way  = '0;
        hit_valid   = '0; hit_set    = '0; hit_way   = '0;
        evict_valid = '0; evict_set  = '0; evict_way = '0;
    endtask

    task automatic set_fill(input int b, input int s, input int w, input logic pf);
        fill_valid[b] = 1'b1;
        fill_is_pf[b] = pf;
        fill_set[b*SB +: SB] = SB'(s);
        fill_way[b*WB +: WB] = WB'(w);
    endtask

    task automatic set_hit(input int b, input int s, input int w);
        hit_valid[b] = 1'b1;
        hit_set[b*SB +: SB] = SB'(s);
        hit_way[b*WB +: WB] = WB'(w);
    endtask

    task automatic set_evict(input int b, input int s, input int w);
        evict_valid[b] = 1'b1;
        evict_set[b*SB +: SB] = SB'(s);
        evict_way[b*WB +: WB] = WB'(w);
    endtask

    // Inputs set after a negedge are sampled at the next posedge; results are
    // read at the following negedge.
    task automatic tick();
        @(negedge clk);
        clr_in();
    endtask

    task automatic test_reset();
        clr_in();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) tick();
        n_cmp++; if (prefetch_requests !== '0) begin n_fail++; $display("FAIL reset_req: got %0d want 0", prefetch_requests); end
        n_cmp++; if (prefetched_blocks !== '0) begin n_fail++; $display("FAIL reset_pf: got %0d want 0", prefetched_blocks); end
        n_cmp++; if (unused_prefetched_blocks !== '0) begin n_fail++; $display("FAIL reset_unused: got %0d want 0", unused_prefetched_blocks); end
    endtask

    task automatic test_req_count();
        repeat (3) begin pf_req_fire = 4'b1111; tick(); end
        n_cmp++; if (prefetch_requests !== 44'd12) begin n_fail++; $display("FAIL req_x3: got %0d want 12", prefetch_requests); end
        n_cmp++; if (prefetched_blocks !== 44'd0) begin n_fail++; $display("FAIL req_pf_idle: got %0d want 0", prefetched_blocks); end
        n_cmp++; if (unused_prefetched_blocks !== 44'd0) begin n_fail++; $display("FAIL req_unused_idle: got %0d want 0", unused_prefetched_blocks); end
    endtask

    task automatic test_unused_basic();
        set_fill(1, 5, 2, 1'b1); tick();
        set_evict(1, 5, 2); tick();
        n_cmp++; if (prefetched_blocks !== 44'd1) begin n_fail++; $display("FAIL basic_pf: got %0d want 1", prefetched_blocks); end
        n_cmp++; if (unused_prefetched_blocks !== 44'd1) begin n_fail++; $display("FAIL basic_unused: got %0d want 1", unused_prefetched_blocks); end
        set_fill(1, 5, 2, 1'b1); tick();
        set_hit(1, 5, 2); tick();
        set_evict(1, 5, 2); tick();
        n_cmp++; if (prefetched_blocks !== 44'd2) begin n_fail++; $display("FAIL hit_pf: got %0d want 2", prefetched_blocks); end
        n_cmp++; if (unused_prefetched_blocks !== 44'd1) begin n_fail++; $display("FAIL hit_unused: got %0d want 1", unused_prefetched_blocks); end
    endtask

    task automatic test_replace();
        set_fill(0, 3, 0, 1'b1); tick();
        set_evict(0, 3, 0); set_fill(0, 3, 0, 1'b1); tick();
        n_cmp++; if (prefetched_blocks !== 44'd4) begin n_fail++; $display("FAIL repl_pf: got %0d want 4", prefetched_blocks); end
        n_cmp++; if (unused_prefetched_blocks !== 44'd2) begin n_fail++; $display("FAIL repl_unused: got %0d want 2", unused_prefetched_blocks); end
        set_evict(0, 3, 0); tick();
        n_cmp++; if (unused_prefetched_blocks !== 44'd3) begin n_fail++; $display("FAIL repl_reevict: got %0d want 3", unused_prefetched_blocks); end
    endtask

    task automatic test_hit_evict();
        set_fill(2, 7, 1, 1'b1); tick();
        set_hit(2, 7, 1); set_evict(2, 7, 1); tick();
        n_cmp++; if (unused_prefetched_blocks !== 44'd3) begin n_fail++; $display("FAIL hitev_unused: got %0d want 3", unused_prefetched_blocks); end
        set_evict(2, 7, 1); tick();
        n_cmp++; if (unused_prefetched_blocks !== 44'd3) begin n_fail++; $display("FAIL hitev_bitclr: got %0d want 3", unused_prefetched_blocks); end
        set_fill(3, 9, 3, 1'b1); tick();
        set_fill(3, 9, 3, 1'b0); tick();
        set_evict(3, 9, 3); tick();
        n_cmp++; if (prefetched_blocks !== 44'd6) begin n_fail++; $display("FAIL demand_pf: got %0d want 6", prefetched_blocks); end
        n_cmp++; if (unused_prefetched_blocks !== 44'd3) begin n_fail++; $display("FAIL demand_unused: got %0d want 3", unused_prefetched_blocks); end
    endtask

    task automatic test_multi_bank();
        for (int b = 0; b < NB; b++) set_fill(b, 1, 0, 1'b1);
        pf_req_fire = 4'b1010;
        tick();
        n_cmp++; if (prefetched_blocks !== 44'd10) begin n_fail++; $display("FAIL multi_pf: got %0d want 10", prefetched_blocks); end
        n_cmp++; if (prefetch_requests !== 44'd14) begin n_fail++; $display("FAIL multi_req: got %0d want 14", prefetch_requests); end
        set_fill(0, 2, 1, 1'b1); tick();
        // bank1 set2/way1 was never prefetched in bank1, only in bank0
        set_evict(1, 2, 1); tick();
        for (int b = 1; b < NB; b++) set_evict(b, 1, 0);
        tick();
        n_cmp++; if (unused_prefetched_blocks !== 44'd6) begin n_fail++; $display("FAIL multi_unused: got %0d want 6", unused_prefetched_blocks); end
        set_evict(0, 1, 0); tick();
        n_cmp++; if (unused_prefetched_blocks !== 44'd7) begin n_fail++; $display("FAIL multi_bank0: got %0d want 7", unused_prefetched_blocks); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (prefetch_requests !== '0) begin n_fail++; $display("FAIL areset_req: got %0d want 0", prefetch_requests); end
        n_cmp++; if (prefetched_blocks !== '0) begin n_fail++; $display("FAIL areset_pf: got %0d want 0", prefetched_blocks); end
        n_cmp++; if (unused_prefetched_blocks !== '0) begin n_fail++; $display("FAIL areset_unused: got %0d want 0", unused_prefetched_blocks); end
        @(negedge clk);
        reset = 1'b0;
        // bank0 set2/way1 was tracked before the reset
        set_evict(0, 2, 1); tick();
        n_cmp++; if (unused_prefetched_blocks !== '0) begin n_fail++; $display("FAIL areset_bits: got %0d want 0", unused_prefetched_blocks); end
    endtask

    task automatic test_wrap();
        logic [CW-1:0] preload;
        preload = {{(CW-1){1'b1}}, 1'b0};
        force dut.pf_req_cnt = preload;
        #1 release dut.pf_req_cnt;
        pf_req_fire = 4'b0111;
        tick();
        n_cmp++; if (prefetch_requests !== 44'd1) begin n_fail++; $display("FAIL wrap_req: got %0h want 1", prefetch_requests); end
    endtask

    task automatic test_clear();
        clr_in();
        reset = 1'b1; #1 reset = 1'b0;
        pf_req_fire = 4'b1111;
        tick();
        pf_req_fire = 4'b0001; set_fill(0, 6, 0, 1'b1); tick();
        n_cmp++; if (prefetch_requests !== 44'd5) begin n_fail++; $display("FAIL preclr_req: got %0d want 5", prefetch_requests); end
        n_cmp++; if (prefetched_blocks !== 44'd1) begin n_fail++; $display("FAIL preclr_pf: got %0d want 1", prefetched_blocks); end
        perf_clear = 1'b1; pf_req_fire = 4'b1111; set_fill(1, 6, 0, 1'b1); tick();
        n_cmp++; if (prefetch_requests !== '0) begin n_fail++; $display("FAIL clr_req: got %0d want 0", prefetch_requests); end
        n_cmp++; if (prefetched_blocks !== '0) begin n_fail++; $display("FAIL clr_pf: got %0d want 0", prefetched_blocks); end
        n_cmp++; if (unused_prefetched_blocks !== '0) begin n_fail++; $display("FAIL clr_unused: got %0d want 0", unused_prefetched_blocks); end
        set_evict(0, 6, 0); set_evict(1, 6, 0); pf_req_fire = 4'b0001; tick();
        n_cmp++; if (unused_prefetched_blocks !== '0) begin n_fail++; $display("FAIL clr_bits: got %0d want 0", unused_prefetched_blocks); end
        n_cmp++; if (prefetch_requests !== 44'd1) begin n_fail++; $display("FAIL postclr_req: got %0d want 1", prefetch_requests); end
    endtask

    initial begin
        test_reset();
        test_req_count();
        test_unused_basic();
        test_replace();
        test_hit_evict();
        test_multi_bank();
        test_async_reset();
        test_wrap();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vx_dcache_prefetch_perf.md
Name: vx_dcache_prefetch_perf

Overview:
Generates the three dcache prefetch performance counters: prefetch requests issued, prefetched blocks filled, and prefetched blocks evicted unused. It sits inside the dcache, directly upstream of the memsys perf interface. It takes per-bank event strobes from the prefetcher and the bank pipelines. It tracks one "prefetched, not yet demanded" bit per cache line, so evictions of untouched prefetched lines can be counted.

Parameters:
NUM_BANKS, 4, number of dcache banks; every per-bank port is NUM_BANKS lanes packed LSB-first
NUM_SETS, 64, sets per bank (power of 2, ≥2)
NUM_WAYS, 4, ways per set (power of 2, ≥1)
CTR_WIDTH, 44, counter width; equals the perf counter width
SET_BITS, log2(NUM_SETS), derived
WAY_BITS, max(1, log2(NUM_WAYS)), derived

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
perf_clear  in  1  sync clear of all counters and tracking bits
pf_req_fire  in  NUM_BANKS  prefetch request accepted by bank b this cycle
fill_valid  in  NUM_BANKS  line fill completing in bank b
fill_is_pf  in  NUM_BANKS  fill originated from a prefetch
fill_set  in  NUM_BANKS*SET_BITS  fill set index
fill_way  in  NUM_BANKS*WAY_BITS  fill way
hit_valid  in  NUM_BANKS  demand (core) access hit in bank b
hit_set  in  NUM_BANKS*SET_BITS  hit set
hit_way  in  NUM_BANKS*WAY_BITS  hit way
evict_valid  in  NUM_BANKS  valid line evicted or invalidated in bank b
evict_set  in  NUM_BANKS*SET_BITS  evict set
evict_way  in  NUM_BANKS*WAY_BITS  evict way
prefetch_requests  out  CTR_WIDTH  total prefetch requests
prefetched_blocks  out  CTR_WIDTH  total prefetch fills
unused_prefetched_blocks  out  CTR_WIDTH  prefetched lines evicted without a demand hit

Behaviour:
- Reset (async assert, sync-safe deassert): all three counters are 0; every tracking bit pf_bit[b][set][way] is 0.
- perf_clear: same effect as reset at the next clk edge. It takes priority over every event in that cycle; events in the clear cycle are dropped.
- Latency: an event in cycle N is visible on the outputs after edge N+1. Outputs come directly from registers; there is no combinational input-to-output path.
- Per cycle:
  - prefetch_requests += popcount(pf_req_fire)
  - prefetched_blocks += popcount(fill_valid & fill_is_pf)
  - unused_prefetched_blocks += count of banks b where evict_valid[b], the tracked bit for (evict_set, evict_way) is 1, and no same-cycle hit in bank b targets the same set/way
- Increments use a width-safe popcount of log2(NUM_BANKS)+1 bits, zero-extended. Counters wrap modulo 2^CTR_WIDTH; they do not saturate.
- Tracking-bit update per bank, evaluated against the pre-cycle value and applied in this order:
  1. hit_valid: clear bit at (hit_set, hit_way).
  2. evict_valid: read the bit for counting, then clear it.
  3. fill_valid: write bit at (fill_set, fill_way) = fill_is_pf. Fill wins over hit or evict to the same line in the same cycle.
- Same-cycle combinations on one line:
  - Evict plus fill (replacement): count uses the old bit; the new bit comes from the fill.
  - Hit plus evict: no unused count.
  - Hit plus fill: bit = fill_is_pf.
- A prefetch fill to a line whose bit is already 1: prefetched_blocks still increments; the bit stays 1.
- A demand fill (fill_is_pf=0) clears the bit.
- Banks are fully independent. Any combination of lanes may be active in the same cycle.
- X on index ports is permitted when the matching valid is low and must not affect state.
- Storage: one register bit per line, NUM_BANKS*NUM_SETS*NUM_WAYS flops, no RAM. Up to 3 writes per bank per cycle, each to a distinct or the same line, resolved per the priority above.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0. Assert reset mid-run with nonzero counts -> outputs 0 immediately (async), with no clk edge needed.
- pf_req_fire=4'b1111 for 3 cycles -> prefetch_requests=12 one cycle after the last fire. Other counters stay 0.
- Bank1: fill set 5 way 2 with is_pf=1; then evict set 5 way 2 -> prefetched_blocks=1, unused_prefetched_blocks=1. Repeat with a hit on set 5 way 2 between fill and evict -> unused unchanged.
- Same cycle in bank0: evict set 3 way 0 (bit=1) plus prefetch fill set 3 way 0 -> unused+1, prefetched+1. Tracking bit=1, so a later evict gives unused+1 again.
- Same cycle hit and evict on a tracked line -> unused+0, bit=0. Demand fill over a tracked line, then evict -> unused+0.
- Preload prefetch_requests to 2^44−2 (force), then fire 3 lanes -> value wraps to 1. perf_clear concurrent with fire=4'b1111 -> all outputs 0 next cycle.
